// File: rtl/sort8_engine.sv
// sort8_engine: loads a block of DEPTH unsigned elements, bubble-sorts them in
// place with one shared comparator (one compare per cycle), then streams them
// out smallest first. The load and unload sides use valid/ready handshakes.
module sort8_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [5:0]       sort_cycles
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_CMP = AW'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_OUT
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr, j, pass;
    logic             swapped;

    logic [AW-1:0]    j_inc;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             cmp_gt;
    logic             end_of_pass, do_next_pass;
    logic             load_fire, out_fire;

    // Shared comparator, handshake decode and end-of-pass decision.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so every read sees the
        // value assigned just above it; registers below use '<=' only.
        j_inc        = j + 1'b1;
        cmp_a        = mem[j];
        cmp_b        = mem[j_inc];
        cmp_gt       = (cmp_a > cmp_b);
        load_fire    = (state == S_LOAD) && in_valid;
        out_fire     = (state == S_OUT) && out_ready;
        end_of_pass  = (state == S_SORT) && (j == LAST_CMP);
        do_next_pass = (swapped || cmp_gt) && (pass < LAST_CMP);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_LOAD;
        else     state <= state_next;
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        out_data   = mem[rptr];
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (load_fire && (wptr == LAST_IDX)) state_next = S_SORT;
            end
            S_SORT: begin
                busy = 1'b1;
                if (end_of_pass && !do_next_pass) state_next = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_fire && (rptr == LAST_IDX)) state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    // Pointers, pass bookkeeping and the sort-latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            j           <= '0;
            pass        <= '0;
            swapped     <= 1'b0;
            sort_cycles <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_fire) begin
                        if (wptr == LAST_IDX) begin
                            wptr        <= '0;
                            j           <= '0;
                            pass        <= '0;
                            swapped     <= 1'b0;
                            sort_cycles <= '0;
                        end else begin
                            wptr <= wptr + 1'b1;
                        end
                    end
                end
                S_SORT: begin
                    if (sort_cycles != 6'd63) sort_cycles <= sort_cycles + 6'd1;
                    if (cmp_gt) swapped <= 1'b1;
                    if (!end_of_pass) begin
                        j <= j_inc;
                    end else if (do_next_pass) begin
                        pass    <= pass + 1'b1;
                        j       <= '0;
                        swapped <= 1'b0;
                    end else begin
                        rptr <= '0;
                    end
                end
                S_OUT: begin
                    if (out_fire) begin
                        if (rptr == LAST_IDX) begin
                            rptr <= '0;
                            wptr <= '0;
                        end else begin
                            rptr <= rptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Element storage: written on load, swapped in place during the sort.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; its contents are
        // meaningless until a full block has been loaded.
        if (load_fire) begin
            mem[wptr] <= in_data;
        end else if ((state == S_SORT) && cmp_gt) begin
            mem[j]     <= cmp_b;
            mem[j_inc] <= cmp_a;
        end
    end

endmodule

// File: tb/tb_sort8_engine.sv
// Bench for sort8_engine: table-driven blocks for the DEPTH=8 build with a
// scoreboard of expected sorted outputs, plus mid-sort reset and a DEPTH=4
// build loaded with gapped in_valid.
module tb_sort8_engine;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, busy;
    logic [7:0] out_data;
    logic [5:0] sort_cycles;

    logic       in_valid4, out_ready4;
    logic [7:0] in_data4;
    logic       in_ready4, out_valid4, busy4;
    logic [7:0] out_data4;
    logic [5:0] sort_cycles4;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0][7:0] d;
        int              exp_cycles;
        logic [3:0]      pat;
        bit              junk;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    sort8_engine #(.WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .sort_cycles(sort_cycles)
    );

    sort8_engine #(.WIDTH(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_data(in_data4),
        .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
        .out_ready(out_ready4), .busy(busy4), .sort_cycles(sort_cycles4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0][7:0] pack8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        logic [7:0][7:0] r;
        r[0] = b0; r[1] = b1; r[2] = b2; r[3] = b3;
        r[4] = b4; r[5] = b5; r[6] = b6; r[7] = b7;
        return r;
    endfunction

    // Reference model: insertion sort, results appended to the scoreboard.
    function automatic void push_sorted(input logic [7:0][7:0] d);
        logic [7:0] a[8];
        logic [7:0] t;
        for (int i = 0; i < 8; i++) a[i] = d[i];
        for (int i = 1; i < 8; i++)
            for (int k = i; k > 0 && a[k-1] > a[k]; k--) begin
                t = a[k]; a[k] = a[k-1]; a[k-1] = t;
            end
        for (int i = 0; i < 8; i++) sb.push_back(a[i]);
    endfunction

    // Load one block with in_valid held high; ends on the cycle after the last accept.
    task automatic load8(input logic [7:0][7:0] d, input bit push, input bit junk);
        int n;
        if (push) push_sorted(d);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d[k];
            n = 0;
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) check("load_timeout", 32'd0, 32'd1);
        end
        @(negedge clk);
        in_valid = junk;
        in_data  = 8'hAA;
        check("busy_after_load", busy, 1'b1);
        check("in_ready_after_load", in_ready, 1'b0);
    endtask

    // Count SORT cycles until out_valid, then compare both counts.
    task automatic wait_sort8(input int exp_cycles);
        int cnt = 0;
        int n = 0;
        while (!out_valid && n < 200) begin
            if (busy) cnt++;
            @(negedge clk);
            n++;
        end
        check("out_valid_arrives", out_valid, 1'b1);
        check("sort_cycles", sort_cycles, exp_cycles);
        check("busy_cycles", cnt, exp_cycles);
    endtask

    // Drain one block with a repeating out_ready pattern, popping the scoreboard.
    task automatic drain8(input logic [3:0] pat);
        int         hs = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        bit         early_ready = 1'b0;
        logic [7:0] held = 8'h00;
        logic [7:0] exp;
        while (hs < 8 && cyc < 200) begin
            @(negedge clk);
            out_ready = pat[cyc % 4];
            if (stalled) check("out_data_hold", out_data, held);
            check("out_valid_during_out", out_valid, 1'b1);
            if (in_ready) early_ready = 1'b1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    check("out_data", out_data, exp);
                end
                hs++;
                stalled = 1'b0;
            end else begin
                stalled = out_valid;
                held    = out_data;
            end
            cyc++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("handshakes", hs, 8);
        check("in_ready_early", early_ready, 1'b0);
        check("in_ready_after_out", in_ready, 1'b1);
        check("out_valid_after_out", out_valid, 1'b0);
        if (pat == 4'hF) check("drain_cycles", cyc, 8);
    endtask

    initial begin
        int acc;
        int n;
        int cnt;
        logic [7:0] d4[4];

        vecs[0] = '{pack8(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80), 7, 4'hF, 1'b0};
        vecs[1] = '{pack8(8'hFF, 8'hE0, 8'hC0, 8'hA0, 8'h80, 8'h60, 8'h40, 8'h00), 49, 4'hF, 1'b0};
        vecs[2] = '{pack8(8'h05, 8'h03, 8'h05, 8'h00, 8'hFF, 8'h03, 8'h7F, 8'h80), 28, 4'hF, 1'b0};
        vecs[3] = '{pack8(8'h40, 8'h11, 8'h99, 8'h11, 8'h02, 8'hC8, 8'h7E, 8'h33), 35, 4'b1001, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        in_valid4 = 1'b0; in_data4 = 8'h00; out_ready4 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_sort_cycles", sort_cycles, 6'd0);

        for (int v = 0; v < 4; v++) begin
            load8(vecs[v].d, 1'b1, vecs[v].junk);
            wait_sort8(vecs[v].exp_cycles);
            drain8(vecs[v].pat);
        end

        // Reset during SORT cycle 10 of a reverse-sorted block.
        load8(vecs[1].d, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sort_cycles", sort_cycles, 6'd0);
        load8(vecs[0].d, 1'b1, 1'b0);
        wait_sort8(7);
        drain8(4'hF);

        // DEPTH=4 build: in_valid every third cycle, junk offered during SORT.
        d4[0] = 8'd4; d4[1] = 8'd3; d4[2] = 8'd2; d4[3] = 8'd1;
        acc = 0;
        n = 0;
        while (acc < 4 && n < 100) begin
            @(negedge clk);
            in_valid4 = (n % 3 == 2);
            in_data4  = in_valid4 ? d4[acc] : 8'hEE;
            if (in_valid4 && in_ready4) acc++;
            n++;
        end
        @(negedge clk);
        in_valid4 = 1'b1;
        in_data4  = 8'h00;
        check("d4_accepted", acc, 4);
        check("d4_busy", busy4, 1'b1);
        check("d4_in_ready_sort", in_ready4, 1'b0);
        cnt = 0;
        n = 0;
        while (!out_valid4 && n < 100) begin
            if (busy4) cnt++;
            @(negedge clk);
            n++;
        end
        check("d4_sort_cycles", sort_cycles4, 6'd9);
        check("d4_busy_cycles", cnt, 9);
        acc = 0;
        n = 0;
        while (acc < 4 && n < 100) begin
            @(negedge clk);
            out_ready4 = 1'b1;
            if (out_valid4) begin
                check("d4_out_data", out_data4, acc + 1);
                acc++;
            end
            n++;
        end
        @(negedge clk);
        out_ready4 = 1'b0;
        in_valid4  = 1'b0;
        check("d4_handshakes", acc, 4);
        check("d4_in_ready_after", in_ready4, 1'b1);
        check("d4_out_valid_after", out_valid4, 1'b0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
